// File: rtl/decode_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue_ctrl_if
// Brief    : Decode/issue handshake bundle between front end and issue control.
// Revision : 1.0 - initial release
// ============================================================================
interface decode_issue_ctrl_if #(
    parameter int NREGS = 32,
    parameter int CNT_W = 8
);
    logic             instr_valid;
    logic [31:0]      Instruccion;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic             br_done;
    logic             br_taken;
    logic             issue;
    logic             stall;
    logic             flush;
    logic [NREGS-1:0] busy_mask;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_err;

    modport master (
        output instr_valid, Instruccion, wb_valid, wb_rd, br_done, br_taken,
        input  issue, stall, flush, busy_mask, stall_cnt, stall_err
    );

    modport slave (
        input  instr_valid, Instruccion, wb_valid, wb_rd, br_done, br_taken,
        output issue, stall, flush, busy_mask, stall_cnt, stall_err
    );
endinterface
`default_nettype wire

// File: rtl/decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue_ctrl
// Brief    : Decode-stage issue/stall/flush controller with register scoreboard.
//            Optional macro FORWARD_EN: same-cycle writeback hides the hazard.
// Revision : 1.0 - initial release
// ============================================================================
module decode_issue_ctrl #(
    parameter int NREGS     = 32,
    parameter int MAX_STALL = 255,
    parameter int CNT_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    decode_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STALL_HAZ = 2'd1,
        WAIT_BR   = 2'd2,
        FLUSH     = 2'd3
    } state_t;

    localparam logic [4:0]       OP_LV       = 5'd1;
    localparam logic [4:0]       OP_CP       = 5'd6;
    localparam logic [4:0]       OP_B        = 5'd7;
    localparam logic [4:0]       OP_BEQ      = 5'd8;
    localparam logic [4:0]       OP_SLR      = 5'd9;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(MAX_STALL);

    state_t           state;
    state_t           state_nx;
    logic             issue_q;
    logic             stall_q;
    logic             flush_q;
    logic             err_q;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_nx;
    logic [NREGS-1:0] wb_clr;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] check_mask;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nx;
    logic [4:0]       opcode;
    logic [4:0]       dest;
    logic [4:0]       src_a;
    logic [4:0]       src_b;
    logic             has_dest;
    logic             use_a;
    logic             use_b;
    logic             hazard;
    logic             do_issue;
    logic             stall_nx;
    logic             unused_instr_bits;

    assign opcode = bus.Instruccion[31:27];

    always_comb begin
        has_dest = 1'b0;
        use_a    = 1'b0;
        use_b    = 1'b0;
        dest     = 5'd0;
        src_a    = 5'd0;
        src_b    = 5'd0;
        case (opcode)
            5'd2, 5'd3, 5'd4, 5'd5: begin
                has_dest = 1'b1;
                use_a    = 1'b1;
                use_b    = 1'b1;
                dest     = bus.Instruccion[22:18];
                src_a    = bus.Instruccion[13:9];
                src_b    = bus.Instruccion[4:0];
            end
            OP_LV: begin
                has_dest = 1'b1;
                dest     = bus.Instruccion[24:20];
            end
            OP_CP: begin
                has_dest = 1'b1;
                dest     = bus.Instruccion[22:18];
            end
            OP_SLR: begin
                has_dest = 1'b1;
                use_a    = 1'b1;
                dest     = bus.Instruccion[24:20];
                src_a    = bus.Instruccion[24:20];
            end
            OP_BEQ: begin
                use_a    = 1'b1;
                use_b    = 1'b1;
                src_a    = bus.Instruccion[22:18];
                src_b    = bus.Instruccion[13:9];
            end
            default: ;
        endcase
    end

    always_comb begin
        wb_clr   = '0;
        set_mask = '0;
        if (bus.wb_valid) begin
            wb_clr[bus.wb_rd] = 1'b1;
        end
        if (has_dest) begin
            set_mask[dest] = 1'b1;
        end
    end

`ifdef FORWARD_EN
    assign check_mask = busy_q & ~wb_clr;
`else
    assign check_mask = busy_q;
`endif

    assign hazard = bus.instr_valid &&
                    ((use_a && check_mask[src_a]) ||
                     (use_b && check_mask[src_b]) ||
                     (has_dest && check_mask[dest]));

    assign do_issue = ((state == RUN) || (state == STALL_HAZ)) &&
                      bus.instr_valid && !hazard;

    always_comb begin
        state_nx = state;
        case (state)
            RUN, STALL_HAZ: begin
                if (do_issue) begin
                    if (opcode == OP_B) begin
                        state_nx = FLUSH;
                    end else if (opcode == OP_BEQ) begin
                        state_nx = WAIT_BR;
                    end else begin
                        state_nx = RUN;
                    end
                end else if (hazard) begin
                    state_nx = STALL_HAZ;
                end else begin
                    state_nx = RUN;
                end
            end
            WAIT_BR: begin
                if (bus.br_done) begin
                    state_nx = bus.br_taken ? FLUSH : RUN;
                end
            end
            FLUSH:   state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // A new writer's set wins over a same-cycle writeback clear of that register.
    assign busy_nx  = (busy_q & ~wb_clr) | (do_issue ? set_mask : '0);
    assign stall_nx = (state_nx == STALL_HAZ) || (state_nx == WAIT_BR);
    assign cnt_nx   = !stall_nx ? '0 :
                      ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= RUN;
            issue_q <= 1'b0;
            stall_q <= 1'b0;
            flush_q <= 1'b0;
            busy_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            issue_q <= do_issue;
            stall_q <= stall_nx;
            flush_q <= (state_nx == FLUSH);
            busy_q  <= busy_nx;
            cnt_q   <= cnt_nx;
            if (stall_nx && (cnt_nx == STALL_LIMIT)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.issue     = issue_q;
    assign bus.stall     = stall_q;
    assign bus.flush     = flush_q;
    assign bus.busy_mask = busy_q;
    assign bus.stall_cnt = cnt_q;
    assign bus.stall_err = err_q;

    assign unused_instr_bits = ^{bus.Instruccion[26:25], bus.Instruccion[17:14],
                                 bus.Instruccion[8:5]};
endmodule
`default_nettype wire

// File: tb/tb_decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_issue_ctrl
// Brief    : Directed + randomized bench for decode_issue_ctrl against a
//            register-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_issue_ctrl;
    localparam int MAX_STALL = 255;
    localparam int CNT_SAT   = 255;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    decode_issue_ctrl_if #(.NREGS(32), .CNT_W(8)) bus ();

    decode_issue_ctrl #(.NREGS(32), .MAX_STALL(MAX_STALL), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: pending-write flags per register plus pipeline status.
    bit m_busy [32];
    bit m_wait_br;
    bit m_flush;
    bit m_stall;
    bit m_issue;
    bit m_err;
    int m_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void regs_of(input logic [31:0] ins, output int dst, output int sa, output int sb);
        int op;
        op  = int'(ins[31:27]);
        dst = -1;
        sa  = -1;
        sb  = -1;
        if (op >= 2 && op <= 5) begin
            dst = int'(ins[22:18]); sa = int'(ins[13:9]); sb = int'(ins[4:0]);
        end else if (op == 1) begin
            dst = int'(ins[24:20]);
        end else if (op == 6) begin
            dst = int'(ins[22:18]);
        end else if (op == 9) begin
            dst = int'(ins[24:20]); sa = dst;
        end else if (op == 8) begin
            sa = int'(ins[22:18]); sb = int'(ins[13:9]);
        end
    endfunction

    function automatic bit blocked(input int r, input bit wv, input logic [4:0] wr);
        if (r < 0) return 1'b0;
`ifdef FORWARD_EN
        if (wv && int'(wr) == r) return 1'b0;
`endif
        return m_busy[r];
    endfunction

    task automatic model_step(input bit rst_v, input bit iv, input logic [31:0] ins,
                              input bit wv, input logic [4:0] wr, input bit bd, input bit bt);
        int dst, sa, sb, setr, op;
        bit haz, ni, nf, ns;
        if (!rst_v) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_wait_br = 0; m_flush = 0; m_stall = 0; m_issue = 0; m_err = 0; m_cnt = 0;
            return;
        end
        ni = 0; nf = 0; ns = 0; setr = -1;
        op = int'(ins[31:27]);
        if (m_flush) begin
            ni = 0;
        end else if (m_wait_br) begin
            if (bd) begin
                m_wait_br = 0;
                nf = bt;
            end else begin
                ns = 1;
            end
        end else begin
            regs_of(ins, dst, sa, sb);
            haz = iv && (blocked(sa, wv, wr) || blocked(sb, wv, wr) || blocked(dst, wv, wr));
            if (iv && !haz) begin
                ni = 1;
                setr = dst;
                if (op == 7) nf = 1;
                if (op == 8) begin
                    m_wait_br = 1;
                    ns = 1;
                end
            end else if (haz) begin
                ns = 1;
            end
        end
        if (wv) m_busy[wr] = 1'b0;
        if (setr >= 0) m_busy[setr] = 1'b1;
        m_cnt = ns ? ((m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT) : 0;
        if (ns && m_cnt == MAX_STALL) m_err = 1;
        m_flush = nf;
        m_stall = ns;
        m_issue = ni;
    endtask

    task automatic check_outputs();
        logic [31:0] eb;
        for (int i = 0; i < 32; i++) eb[i] = m_busy[i];
        check_val("issue",     32'(bus.issue),     32'(m_issue));
        check_val("stall",     32'(bus.stall),     32'(m_stall));
        check_val("flush",     32'(bus.flush),     32'(m_flush));
        check_val("busy_mask", bus.busy_mask,      eb);
        check_val("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
        check_val("stall_err", 32'(bus.stall_err), 32'(m_err));
    endtask

    task automatic step(input bit rst_v, input bit iv, input logic [31:0] ins,
                        input bit wv, input logic [4:0] wr, input bit bd, input bit bt);
        reset           = rst_v;
        bus.instr_valid = iv;
        bus.Instruccion = ins;
        bus.wb_valid    = wv;
        bus.wb_rd       = wr;
        bus.br_done     = bd;
        bus.br_taken    = bt;
        model_step(rst_v, iv, ins, wv, wr, bd, bt);
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 32'h0, 0, 5'd0, 0, 0);
    endtask

    function automatic logic [31:0] mk_arith(input int op, input int d, input int a, input int b);
        logic [31:0] w;
        w = 32'h0;
        w[31:27] = 5'(op); w[22:18] = 5'(d); w[13:9] = 5'(a); w[4:0] = 5'(b);
        return w;
    endfunction

    function automatic logic [31:0] mk_lv(input int d);
        logic [31:0] w;
        w = 32'h0;
        w[31:27] = 5'd1; w[24:20] = 5'(d);
        return w;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w = w & ~32'h01E0_3018;
        w[31:27] = 5'($urandom_range(0, 12));
        return w;
    endfunction

    initial begin
        logic [31:0] cur;
        logic [4:0]  wr;
        int          pend[$];
        bit          iv, wv, bd;

        // Reset and a single arithmetic issue.
        step(0, 0, 32'h0, 0, 5'd0, 0, 0);
        step(0, 0, 32'h0, 0, 5'd0, 0, 0);
        step(1, 1, mk_arith(2, 3, 1, 2), 0, 5'd0, 0, 0);
        idle(1);

        // RAW hazard on r3 resolved by a writeback two cycles later.
        step(0, 0, 32'h0, 0, 5'd0, 0, 0);
        step(1, 1, mk_arith(2, 3, 1, 2), 0, 5'd0, 0, 0);
        step(1, 1, mk_arith(2, 4, 3, 1), 0, 5'd0, 0, 0);
        step(1, 1, mk_arith(2, 4, 3, 1), 0, 5'd0, 0, 0);
        step(1, 1, mk_arith(2, 4, 3, 1), 1, 5'd3, 0, 0);
        step(1, 1, mk_arith(2, 4, 3, 1), 0, 5'd0, 0, 0);
        idle(2);

        // Unconditional branch, then taken and not-taken conditional branches.
        step(1, 1, mk_arith(7, 0, 0, 0), 0, 5'd0, 0, 0);
        idle(3);
        for (int t = 1; t >= 0; t--) begin
            step(1, 1, mk_arith(8, 1, 2, 0), 0, 5'd0, 0, 0);
            idle(2);
            step(1, 0, 32'h0, 0, 5'd0, 1, t[0]);
            idle(2);
        end

        // Long hazard drives stall_cnt to saturation and sets the sticky error.
        step(1, 1, mk_lv(5), 0, 5'd0, 0, 0);
        for (int i = 0; i < 260; i++) step(1, 1, mk_arith(2, 6, 5, 5), 0, 5'd0, 0, 0);
        step(1, 1, mk_arith(2, 6, 5, 5), 1, 5'd5, 0, 0);
        idle(3);

        // Reset in the middle of a branch wait, then a stale writeback.
        step(1, 1, mk_lv(5), 0, 5'd0, 0, 0);
        step(1, 1, mk_arith(8, 1, 2, 0), 0, 5'd0, 0, 0);
        step(1, 0, 32'h0, 0, 5'd0, 0, 0);
        step(0, 0, 32'h0, 0, 5'd0, 0, 0);
        step(1, 0, 32'h0, 1, 5'd5, 0, 0);
        idle(1);

        // Randomized traffic.
        cur = rand_instr();
        for (int n = 0; n < 4000; n++) begin
            if (m_issue || m_flush || $urandom_range(0, 9) == 0) cur = rand_instr();
            iv = ($urandom_range(0, 99) < 85);
            pend.delete();
            for (int i = 0; i < 32; i++) if (m_busy[i]) pend.push_back(i);
            wv = ($urandom_range(0, 99) < 40);
            if (pend.size() > 0 && $urandom_range(0, 9) < 7)
                wr = 5'(pend[$urandom_range(0, pend.size() - 1)]);
            else
                wr = 5'($urandom_range(0, 7));
            bd = m_wait_br ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) == 0);
            step(($urandom_range(0, 299) != 0), iv, cur, wv, wr, bd, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Issue controller that sequences the decode/register-read stage of the vector processor pipeline.
- Decides each cycle whether the instruction held at decode may issue, must stall, or must be flushed.
- Keeps a 32-entry register scoreboard so an instruction never reads a register with a write still in flight.
- Tracks writebacks and branch resolution (opcodes 7 and 8) and drives the stall/flush controls for fetch and decode.

Parameters:
- NREGS, 32, register file depth; the scoreboard has one bit per register.
- MAX_STALL, 255, stall-cycle limit before stall_err is raised.
- CNT_W, 8, width of stall_cnt; must satisfy 2^CNT_W > MAX_STALL.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- instr_valid  in  1  Instruccion holds a valid instruction at decode.
- Instruccion  in  32  instruction at decode; opcode is [31:27].
- wb_valid  in  1  writeback this cycle.
- wb_rd  in  5  register index being written back.
- br_done  in  1  conditional branch resolved (1-cycle pulse).
- br_taken  in  1  branch outcome; sampled only when br_done=1.
- issue  out  1  instruction accepted this cycle.
- stall  out  1  hold fetch and decode.
- flush  out  1  kill the fetched instruction behind decode.
- busy_mask  out  32  scoreboard; bit i=1 means register i has a write pending.
- stall_cnt  out  CNT_W  consecutive stall cycles, saturating.
- stall_err  out  1  sticky; set when stall_cnt reaches MAX_STALL.

Behaviour:
- Reset (reset=0 at a rising edge): state=RUN, busy_mask=0, stall_cnt=0, stall_err=0, issue=0, stall=0, flush=0.
- Field extraction (lower 5 bits of each field), by opcode:
  - 2–5 (arithmetic): dest=[22:18], srcA=[13:9], srcB=[4:0].
  - 1 (lv): dest=[24:20], no sources.
  - 6 (cp): dest=[22:18], no sources.
  - 9 (slr): dest=[24:20], srcA=dest.
  - 8 (beq): srcA=[22:18], srcB=[13:9], no dest.
  - 10 (gp), 7 (b): no registers.
  - 0 and 11–31: treated as NOP; issue without a scoreboard update.
- hazard=1 when instr_valid=1 and any used source, or the dest (WAW), has its busy_mask bit set after the current cycle's writeback clear is applied (FORWARD_EN only).
- States:
  - RUN:
    - If instr_valid and !hazard: issue=1 for the cycle; set busy[dest] if a dest exists.
    - Opcode 7 → FLUSH. Opcode 8 → WAIT_BR.
    - If hazard: issue=0, stall=1, next state STALL_HAZ.
  - STALL_HAZ: stall=1. Re-evaluate hazard each cycle. When it clears, issue on that cycle with the same effects as RUN, then follow the RUN transitions.
  - WAIT_BR: stall=1, issue=0. On br_done:
    - br_taken=1 → FLUSH.
    - otherwise → RUN with stall released the next cycle.
  - FLUSH: flush=1 and stall=0 for exactly one cycle, then RUN.
- Outputs are registered; issue/stall/flush reflect the state after the edge. Issue-to-scoreboard-visible latency is 1 cycle.
- Writeback: wb_valid clears busy[wb_rd] at the edge. If a set and a clear hit the same index in the same cycle, set wins (new writer).
- Register 0 is tracked like any other register.
- stall_cnt increments on every cycle with stall=1, saturates at 2^CNT_W−1, and clears on the first cycle with stall=0.
- stall_err sets when stall_cnt==MAX_STALL and clears only on reset.
- br_done outside WAIT_BR is ignored.
- instr_valid=0 in RUN: idle, no outputs asserted.
- Reset asserted mid-stall or mid-branch: return to RUN, busy_mask cleared; in-flight writebacks after reset are ignored harmlessly (clear of an already-0 bit).

Optional Feature:
- FORWARD_EN defined: the hazard check uses busy_mask with the same-cycle writeback already cleared (busy & ~(wb_valid<<wb_rd)). A source written back in the same cycle issues without a stall.
- FORWARD_EN undefined: the hazard check uses registered busy_mask only, so a matching writeback still costs one stall cycle.

Test Plan:
- Reset, then add r3,r1,r2 (op 2, dest 3, srcs 1,2) with mask=0 → issue=1 next cycle; busy_mask=0x00000008.
- Issue add r3; next cycle add r4,r3,r1; wb r3 two cycles later → stall=1, stall_cnt counts 1,2. Issue occurs the cycle after wb without FORWARD_EN, or the wb cycle with it.
- Opcode 7 → issue=1, then flush=1 for exactly 1 cycle, then RUN with stall=0.
- Opcode 8 srcs r1,r2 free: br_done=1, br_taken=1 after 3 cycles → stall=1 for 3 cycles, then flush=1 for 1 cycle. Repeat with br_taken=0 → no flush.
- Hold a hazard with no writeback for 260 cycles, MAX_STALL=255 → stall_err=1 at the cycle stall_cnt=255; stall_cnt saturates at 255; stall_err stays 1 after the later release.
- Set busy r5; assert reset=0 for one edge mid WAIT_BR → busy_mask=0, stall=0, state RUN; then wb_valid with wb_rd=5 → mask stays 0.
